// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops one FIFO word per frame and shifts out start, data LSB-first, optional parity, 1-2 stop bits.
// Start bit begins 2 clk after the pop request; new frames wait for i_enable and a non-empty FIFO.
module uart_tx_engine #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_baud_div,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_two_stop,
  input  logic              i_fifo_empty,
  input  logic              i_fifo_valid,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic              i_fifo_parity_error,
  output logic              o_fifo_rd_req,
  output logic              o_txd,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fetch_err,
  output logic              o_fifo_perr
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             parity_en;
    logic             parity_odd;
    logic             two_stop;
  } cfg_t;

  state_t            state;
  state_t            state_nxt;
  cfg_t              cfg;
  logic [DIV_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic              stop_second;
  logic              txd;
  logic              frame_go;
  logic              bit_end;
  logic              last_bit;

  assign bit_end  = (cnt == cfg.div);
  assign last_bit = (bit_idx == LAST_IDX);

  always_comb begin
    state_nxt   = state;
    frame_go    = 1'b0;
    o_done      = 1'b0;
    o_fetch_err = 1'b0;
    o_fifo_perr = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable && !i_fifo_empty) begin
          frame_go  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (i_fifo_valid) begin
          o_fifo_perr = i_fifo_parity_error;
          state_nxt   = START;
        end else begin
          o_fetch_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && last_bit) state_nxt = cfg.parity_en ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end && (!cfg.two_stop || stop_second)) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop during reset would drop a word the engine never sees.
  assign o_fifo_rd_req = frame_go & i_nrst;
  assign o_busy        = (state != IDLE);
  assign o_txd         = txd;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      txd         <= 1'b1;
      cfg         <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (frame_go) cfg <= {i_baud_div, i_parity_en, i_parity_odd, i_two_stop};
        end
        FETCH: begin
          if (i_fifo_valid) begin
            shift       <= i_fifo_data;
            par_bit     <= (^i_fifo_data) ^ cfg.parity_odd;
            cnt         <= '0;
            stop_second <= 1'b0;
            txd         <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (last_bit) begin
              txd <= cfg.parity_en ? par_bit : 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt <= '0;
            txd <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // First stop period marks itself done so a second one ends the frame.
          if (bit_end) begin
            cnt         <= '0;
            stop_second <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: FWFT FIFO model, line decoder against frame bit lists built from data and config.
module tb_uart_tx_engine;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_enable = 1'b0;
  logic [15:0] i_baud_div = '0;
  logic        i_parity_en = 1'b0;
  logic        i_parity_odd = 1'b0;
  logic        i_two_stop = 1'b0;
  logic        i_fifo_empty = 1'b1;
  logic        i_fifo_valid = 1'b0;
  logic [7:0]  i_fifo_data = '0;
  logic        i_fifo_parity_error = 1'b0;
  logic        o_fifo_rd_req, o_txd, o_busy, o_done, o_fetch_err, o_fifo_perr;

  uart_tx_engine #(.DATA_W(8), .DIV_W(16)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_enable(i_enable), .i_baud_div(i_baud_div),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_two_stop(i_two_stop),
    .i_fifo_empty(i_fifo_empty), .i_fifo_valid(i_fifo_valid), .i_fifo_data(i_fifo_data),
    .i_fifo_parity_error(i_fifo_parity_error), .o_fifo_rd_req(o_fifo_rd_req), .o_txd(o_txd),
    .o_busy(o_busy), .o_done(o_done), .o_fetch_err(o_fetch_err), .o_fifo_perr(o_fifo_perr)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;

  // FIFO contents: pushed by the test, consumed through rd_ptr by the FIFO model.
  logic [7:0] push_q[$];
  bit         push_perr[$];
  bit         push_drop[$];
  int         rd_ptr = 0;
  bit         pend = 1'b0;
  int         rdreq_cnt = 0, rd_when_empty = 0, ferr_cnt = 0, perr_cnt = 0;

  always @(negedge i_clk) begin
    pend = o_fifo_rd_req;
    if (o_fifo_rd_req === 1'b1) rdreq_cnt++;
    if (o_fifo_rd_req === 1'b1 && i_fifo_empty) rd_when_empty++;
    if (o_fetch_err === 1'b1) ferr_cnt++;
    if (o_fifo_perr === 1'b1) perr_cnt++;
  end

  always @(posedge i_clk) begin
    #1;
    if (pend && rd_ptr < push_q.size()) begin
      i_fifo_valid        = !push_drop[rd_ptr];
      i_fifo_data         = push_q[rd_ptr];
      i_fifo_parity_error = push_perr[rd_ptr];
      rd_ptr++;
    end else begin
      i_fifo_valid        = 1'b0;
      i_fifo_parity_error = 1'b0;
    end
    i_fifo_empty = (rd_ptr >= push_q.size());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         pe;
    bit         po;
    bit         ts;
    bit         exp_par;
    int         exp_len;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit perr, input bit drop);
    push_q.push_back(d);
    push_perr.push_back(perr);
    push_drop.push_back(drop);
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit po, input bit ts);
    i_baud_div   = 16'(div);
    i_parity_en  = pe;
    i_parity_odd = po;
    i_two_stop   = ts;
  endtask

  // Waits for a start bit, then compares every clock of the frame against the expected bit list.
  task automatic watch_frame(input logic [7:0] d, input int div, input bit pe, input bit po,
                             input bit ts, output int waited, output int done_at,
                             output int bad_bits, output int par_seen);
    logic bits[$];
    int   frame_clks;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ po);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    waited = -1; done_at = -1; bad_bits = 0; par_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      if (o_txd === 1'b0) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) return;
    frame_clks = bits.size() * (div + 1);
    for (int n = 0; n < frame_clks; n++) begin
      if (n > 0) @(negedge i_clk);
      if (o_txd !== bits[n / (div + 1)] || o_busy !== 1'b1) bad_bits++;
      if (pe && n == 9 * (div + 1)) par_seen = int'(o_txd);
      if (o_done === 1'b1 && done_at < 0) done_at = n;
    end
  endtask

  int w, d_at, bad, par, base, base2, cnt_bad, exp_perr;
  logic [7:0] rd;
  int rdiv;
  bit rpe, rpo, rts, rpf;

  initial begin
    tbl[0] = '{8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 40};
    tbl[1] = '{8'h07, 1, 1'b1, 1'b0, 1'b0, 1'b1, 22};
    tbl[2] = '{8'h07, 1, 1'b1, 1'b1, 1'b0, 1'b0, 22};
    tbl[3] = '{8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0, 33};
    tbl[4] = '{8'hFF, 2, 1'b1, 1'b0, 1'b1, 1'b0, 36};
    tbl[5] = '{8'h3C, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12};
    tbl[6] = '{8'h80, 4, 1'b1, 1'b0, 1'b0, 1'b1, 55};
    tbl[7] = '{8'h01, 0, 1'b0, 1'b0, 1'b0, 1'b0, 10};

    repeat (3) tick();
    chk("rst_txd", int'(o_txd), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_rd_req", int'(o_fifo_rd_req), 0);
    chk("rst_fetch_err", int'(o_fetch_err), 0);
    chk("rst_perr", int'(o_fifo_perr), 0);
    tick();
    i_nrst = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      tick();
      set_cfg(tbl[i].div, tbl[i].pe, tbl[i].po, tbl[i].ts);
      i_enable = 1'b1;
      push(tbl[i].data, 1'b0, 1'b0);
      watch_frame(tbl[i].data, tbl[i].div, tbl[i].pe, tbl[i].po, tbl[i].ts, w, d_at, bad, par);
      chk($sformatf("v%0d_start", i), int'(w >= 0), 1);
      chk($sformatf("v%0d_bits", i), bad, 0);
      chk($sformatf("v%0d_len", i), d_at + 1, tbl[i].exp_len);
      if (tbl[i].pe) chk($sformatf("v%0d_parity", i), par, int'(tbl[i].exp_par));
      repeat (3) @(negedge i_clk);
      chk($sformatf("v%0d_idle", i), int'(o_busy), 0);
    end

    // Random frames with config scrambled after the frame has latched it.
    base = perr_cnt;
    exp_perr = 0;
    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom_range(0, 255));
      rdiv = int'($urandom_range(0, 3));
      rpe = ($urandom_range(0, 1) == 1);
      rpo = ($urandom_range(0, 1) == 1);
      rts = ($urandom_range(0, 1) == 1);
      rpf = ($urandom_range(0, 3) == 0);
      tick();
      set_cfg(rdiv, rpe, rpo, rts);
      push(rd, rpf, 1'b0);
      if (rpf) exp_perr++;
      fork
        watch_frame(rd, rdiv, rpe, rpo, rts, w, d_at, bad, par);
        begin
          repeat (3) tick();
          set_cfg(int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
      join
      chk($sformatf("r%0d_bits", i), bad, 0);
      chk($sformatf("r%0d_len", i), d_at + 1, (1 + 8 + int'(rpe) + 1 + int'(rts)) * (rdiv + 1));
      repeat (3) @(negedge i_clk);
    end
    chk("rand_perr_count", perr_cnt - base, exp_perr);

    // Back-to-back frames, two stop bits.
    tick();
    set_cfg(2, 1'b0, 1'b0, 1'b1);
    base = rdreq_cnt;
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    watch_frame(8'h00, 2, 1'b0, 1'b0, 1'b1, w, d_at, bad, par);
    chk("b2b_f1_bits", bad, 0);
    watch_frame(8'hFF, 2, 1'b0, 1'b0, 1'b1, w, d_at, bad, par);
    chk("b2b_gap", w, 2);
    chk("b2b_f2_bits", bad, 0);
    chk("b2b_f2_len", d_at + 1, 33);
    repeat (5) tick();
    chk("b2b_rd_req_count", rdreq_cnt - base, 2);

    // Empty FIFO with enable held.
    cnt_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_fifo_rd_req !== 1'b0 || o_txd !== 1'b1 || o_busy !== 1'b0) cnt_bad++;
    end
    chk("empty_quiet", cnt_bad, 0);

    // Enable dropped mid-frame.
    tick();
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    base = rdreq_cnt;
    push(8'h5A, 1'b0, 1'b0);
    fork
      watch_frame(8'h5A, 1, 1'b0, 1'b0, 1'b0, w, d_at, bad, par);
      begin
        repeat (10) tick();
        i_enable = 1'b0;
        push(8'hC3, 1'b0, 1'b0);
      end
    join
    chk("endrop_bits", bad, 0);
    chk("endrop_len", d_at + 1, 20);
    cnt_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if (o_busy !== 1'b0 || o_txd !== 1'b1) cnt_bad++;
    end
    chk("endrop_no_new_frame", cnt_bad, 0);
    chk("endrop_rd_req_count", rdreq_cnt - base, 1);
    tick();
    i_enable = 1'b1;
    watch_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0, w, d_at, bad, par);
    chk("reenable_bits", bad, 0);

    // Async reset in data bit 3.
    tick();
    push(8'h96, 1'b0, 1'b0);
    w = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_txd === 1'b0) begin
        w = i;
        break;
      end
    end
    chk("rst_mid_start", int'(w >= 0), 1);
    repeat (8) @(negedge i_clk);
    chk("rst_mid_pre_txd", int'(o_txd), 0);
    #2;
    i_nrst = 1'b0;
    #1;
    chk("rst_mid_txd", int'(o_txd), 1);
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_done", int'(o_done), 0);
    tick();
    push(8'h69, 1'b0, 1'b0);
    tick();
    i_nrst = 1'b1;
    watch_frame(8'h69, 1, 1'b0, 1'b0, 1'b0, w, d_at, bad, par);
    chk("rst_fresh_bits", bad, 0);
    chk("rst_fresh_len", d_at + 1, 20);

    // Missing read data, then a word flagged by FIFO parity.
    tick();
    base = ferr_cnt;
    push(8'h11, 1'b0, 1'b1);
    cnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_txd !== 1'b1) cnt_bad++;
    end
    chk("fetch_err_count", ferr_cnt - base, 1);
    chk("fetch_err_line_idle", cnt_bad, 0);
    chk("fetch_err_busy", int'(o_busy), 0);
    tick();
    base2 = perr_cnt;
    push(8'h3C, 1'b1, 1'b0);
    watch_frame(8'h3C, 1, 1'b0, 1'b0, 1'b0, w, d_at, bad, par);
    chk("perr_word_bits", bad, 0);
    chk("perr_count", perr_cnt - base2, 1);

    repeat (5) tick();
    chk("rd_req_never_empty", rd_when_empty, 0);
    chk("rd_req_per_word", rdreq_cnt, push_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
